pc_gen_multi: RTL and testbench
===============================

Name: pc_gen_multi

Overview:
- Registered next-PC generator at the head of the fetch stage. Generalises the combinational PC mux to NUM_SRC prioritised redirect channels, a FETCH_WIDTH-instruction fetch group, and a predictor input.
- Owns the architectural fetch PC register and a ready/valid handshake to fetch.
- A one-entry pending-redirect buffer keeps a redirect raised during a hold.

Parameters:
NUM_SRC, 4, redirect channels; index 0 highest priority (eret, exception, icache replay, branch order)
FETCH_WIDTH, 2, instructions per fetch group; power of two, 1..8
RESET_PC, 32'hbfc0_0000, PC issued after reset

Ports:
clk  in  1  clock
resetn  in  1  asynchronous active-low reset
redir_valid  in  NUM_SRC  per-channel redirect request
redir_pc  in  NUM_SRC*32  per-channel target; channel i at bits [32*i+31:32*i]
pred_taken  in  1  predictor says current group is redirected
pred_pc  in  32  predictor target
hold  in  1  freezes the PC register (e.g. backend full)
fetch_ready  in  1  fetch accepts current group
fetch_valid  out  1  fetch_pc is valid
fetch_pc  out  32  group PC
fetch_mask  out  FETCH_WIDTH  valid slots in group
redir_src  out  $clog2(NUM_SRC+1)  0 = sequential/predicted; i+1 = channel i caused this PC
flush  out  1  one-cycle pulse: fetch_pc was loaded by a redirect
pc_misalign  out  1  fetch_pc[1:0] != 0

Behaviour:
- Async reset (resetn=0):
  - fetch_valid=0, fetch_pc=RESET_PC, redir_src=0, flush=0, pending buffer empty.
  - State BOOT.
- BOOT -> RUN on the first clock after reset release. fetch_valid=1 from then on; it is deasserted only by reset.
- Redirect selection: sel = lowest index i with redir_valid[i]=1; target = redir_pc[i].
- Next-PC priority, evaluated each cycle in RUN (registered, 1-cycle latency):
  1. hold=1:
     - PC, mask and redir_src are unchanged; flush=0.
     - If a redirect is present, it goes to the pending buffer when the buffer is empty or sel < pending index. Otherwise it is dropped.
  2. hold=0, redirect or pending present:
     - Winner is the lower index of new sel and pending; ties go to the new request.
     - fetch_pc <= winner target, redir_src <= winner index+1, flush <= 1.
     - Pending is cleared. This applies regardless of fetch_ready, because a redirect kills the current group.
  3. hold=0, fetch_ready=1, pred_taken=1: fetch_pc <= pred_pc, redir_src <= 0.
  4. hold=0, fetch_ready=1: fetch_pc <= (fetch_pc & ~(FETCH_WIDTH*4-1)) + FETCH_WIDTH*4, redir_src <= 0. 32-bit wrap-around is allowed (0xFFFF_FFF8 + 8 -> 0).
  5. Otherwise hold the current value.
- flush is 1 only in the cycle after a rule-2 load; 0 otherwise.
- fetch_mask (combinational from fetch_pc):
  - off = fetch_pc[log2(FETCH_WIDTH)+1:2]; bits [FETCH_WIDTH-1:off] are set.
  - If pc_misalign=1, only bit off is set.
  - FETCH_WIDTH=1 gives mask 1'b1.
- pc_misalign is combinational from fetch_pc. A misaligned PC is still presented with fetch_valid=1; the exception is taken downstream.
- pred_taken is ignored whenever hold=1 or fetch_ready=0.
- Reset asserted mid-operation discards the pending buffer and any in-flight PC.

Test Plan:
- Reset release -> cycle 1: fetch_valid=1, fetch_pc=0xbfc00000, fetch_mask=2'b11, redir_src=0, flush=0.
- fetch_ready=1 with no redirect, start PC 0xbfc00004 -> mask=2'b10; next PC 0xbfc00008; mask 2'b11.
- redir_valid=4'b1010, redir_pc[1]=0x80001000, redir_pc[3]=0x80002000, fetch_ready=0 -> next cycle fetch_pc=0x80001000, redir_src=2, flush=1; flush=0 the following cycle.
- hold=1 for 3 cycles:
  - Cycle 0: channel 3 requests 0x100.
  - Cycle 1: channel 2 requests 0x200.
  - Cycle 2: nothing requested.
  - Required: PC frozen throughout; after hold drops, fetch_pc=0x200, redir_src=3.
- Same cycle pred_taken=1 (pred_pc=0x400) and redir_valid[0]=1 (0xbfc00380) -> fetch_pc=0xbfc00380, redir_src=1. Separately, pred_taken=1 with fetch_ready=0 -> PC unchanged.
- redir_pc=0x80000002 -> pc_misalign=1, fetch_mask=2'b01. Then resetn=0 with hold=1 and a pending redirect -> after release, fetch_pc=0xbfc00000 and the pending redirect is never applied.

Source files
------------

// File: rtl/pc_gen_multi.sv
// Fetch-PC register with prioritised redirect channels, predictor input and a one-entry pending-redirect buffer.
// One-cycle registered latency; hold freezes the PC while parking the best redirect, and fetch_ready stalls sequential advance.
module pc_gen_multi #(
    parameter int          NUM_SRC     = 4,
    parameter int          FETCH_WIDTH = 2,
    parameter logic [31:0] RESET_PC    = 32'hbfc0_0000,
    localparam int         SRCW        = $clog2(NUM_SRC + 1)
) (
    input  logic                     clk,
    input  logic                     resetn,
    input  logic [NUM_SRC-1:0]       redir_valid,
    input  logic [NUM_SRC*32-1:0]    redir_pc,
    input  logic                     pred_taken,
    input  logic [31:0]              pred_pc,
    input  logic                     hold,
    input  logic                     fetch_ready,
    output logic                     fetch_valid,
    output logic [31:0]              fetch_pc,
    output logic [FETCH_WIDTH-1:0]   fetch_mask,
    output logic [SRCW-1:0]          redir_src,
    output logic                     flush,
    output logic                     pc_misalign
);

    localparam logic [31:0] GROUP_BYTES = 32'(FETCH_WIDTH * 4);
    localparam logic [31:0] GROUP_MASK  = 32'(FETCH_WIDTH * 4 - 1);

    typedef enum logic {BOOT, RUN} state_t;

    state_t            state_q, state_d;
    logic              fetch_valid_q, fetch_valid_d;
    logic [31:0]       pc_q, pc_d;
    logic [SRCW-1:0]   src_q, src_d;
    logic              flush_q, flush_d;
    logic              pend_vld_q, pend_vld_d;
    logic [SRCW-1:0]   pend_idx_q, pend_idx_d;
    logic [31:0]       pend_pc_q, pend_pc_d;

    logic              redir_any;
    logic [SRCW-1:0]   sel_idx;
    logic [31:0]       sel_pc;
    logic [31:0]       seq_pc;
    logic [31:0]       slot_off;

    // Descending scan so the lowest-numbered active channel wins.
    always_comb begin
        redir_any = 1'b0;
        sel_idx   = '0;
        sel_pc    = '0;
        for (int i = NUM_SRC - 1; i >= 0; i--) begin
            if (redir_valid[i]) begin
                redir_any = 1'b1;
                sel_idx   = SRCW'(i);
                sel_pc    = redir_pc[32*i +: 32];
            end
        end
    end

    assign seq_pc = (pc_q & ~GROUP_MASK) + GROUP_BYTES;

    always_comb begin
        state_d       = state_q;
        fetch_valid_d = fetch_valid_q;
        pc_d          = pc_q;
        src_d         = src_q;
        flush_d       = 1'b0;
        pend_vld_d    = pend_vld_q;
        pend_idx_d    = pend_idx_q;
        pend_pc_d     = pend_pc_q;

        if (state_q == BOOT) begin
            state_d       = RUN;
            fetch_valid_d = 1'b1;
        end else if (hold) begin
            if (redir_any && (!pend_vld_q || sel_idx < pend_idx_q)) begin
                pend_vld_d = 1'b1;
                pend_idx_d = sel_idx;
                pend_pc_d  = sel_pc;
            end
        end else if (redir_any || pend_vld_q) begin
            // A redirect kills the current group, so fetch_ready is irrelevant here.
            if (redir_any && (!pend_vld_q || sel_idx <= pend_idx_q)) begin
                pc_d  = sel_pc;
                src_d = SRCW'(sel_idx + 1'b1);
            end else begin
                pc_d  = pend_pc_q;
                src_d = SRCW'(pend_idx_q + 1'b1);
            end
            flush_d    = 1'b1;
            pend_vld_d = 1'b0;
        end else if (fetch_ready) begin
            pc_d  = pred_taken ? pred_pc : seq_pc;
            src_d = '0;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q       <= BOOT;
            fetch_valid_q <= 1'b0;
            pc_q          <= RESET_PC;
            src_q         <= '0;
            flush_q       <= 1'b0;
            pend_vld_q    <= 1'b0;
            pend_idx_q    <= '0;
            pend_pc_q     <= '0;
        end else begin
            state_q       <= state_d;
            fetch_valid_q <= fetch_valid_d;
            pc_q          <= pc_d;
            src_q         <= src_d;
            flush_q       <= flush_d;
            pend_vld_q    <= pend_vld_d;
            pend_idx_q    <= pend_idx_d;
            pend_pc_q     <= pend_pc_d;
        end
    end

    assign slot_off    = (pc_q >> 2) & 32'(FETCH_WIDTH - 1);
    assign pc_misalign = (pc_q[1:0] != 2'b00);

    always_comb begin
        fetch_mask = '0;
        for (int j = 0; j < FETCH_WIDTH; j++) begin
            if (pc_misalign)
                fetch_mask[j] = (32'(j) == slot_off);
            else
                fetch_mask[j] = (32'(j) >= slot_off);
        end
    end

    assign fetch_valid = fetch_valid_q;
    assign fetch_pc    = pc_q;
    assign redir_src   = src_q;
    assign flush       = flush_q;

endmodule

// File: tb/tb_pc_gen_multi.sv
// Directed bench for pc_gen_multi with hand-computed expectations.
module tb_pc_gen_multi;

    logic         clk = 1'b0;
    logic         resetn;
    logic [3:0]   redir_valid;
    logic [127:0] redir_pc;
    logic         pred_taken;
    logic [31:0]  pred_pc;
    logic         hold;
    logic         fetch_ready;
    logic         fetch_valid;
    logic [31:0]  fetch_pc;
    logic [1:0]   fetch_mask;
    logic [2:0]   redir_src;
    logic         flush;
    logic         pc_misalign;

    int n_vec = 0;
    int n_err = 0;

    pc_gen_multi dut (
        .clk         (clk),
        .resetn      (resetn),
        .redir_valid (redir_valid),
        .redir_pc    (redir_pc),
        .pred_taken  (pred_taken),
        .pred_pc     (pred_pc),
        .hold        (hold),
        .fetch_ready (fetch_ready),
        .fetch_valid (fetch_valid),
        .fetch_pc    (fetch_pc),
        .fetch_mask  (fetch_mask),
        .redir_src   (redir_src),
        .flush       (flush),
        .pc_misalign (pc_misalign)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clr_redir();
        redir_valid = '0;
        redir_pc    = '0;
    endtask

    task automatic req(input int ch, input logic [31:0] pc);
        redir_valid[ch]      = 1'b1;
        redir_pc[32*ch +: 32] = pc;
    endtask

    initial begin
        resetn = 1'b0; hold = 1'b0; fetch_ready = 1'b0;
        pred_taken = 1'b0; pred_pc = '0;
        clr_redir();
        #12;
        chk("rst_valid", 32'(fetch_valid), 32'd0);
        chk("rst_pc",    fetch_pc,         32'hbfc0_0000);
        chk("rst_src",   32'(redir_src),   32'd0);
        chk("rst_flush", 32'(flush),       32'd0);

        @(posedge clk); #1;
        resetn = 1'b1;
        step();
        chk("boot_valid", 32'(fetch_valid), 32'd1);
        chk("boot_pc",    fetch_pc,         32'hbfc0_0000);
        chk("boot_mask",  32'(fetch_mask),  32'h3);
        chk("boot_src",   32'(redir_src),   32'd0);
        chk("boot_flush", 32'(flush),       32'd0);

        // Move to 0xbfc00004 then advance sequentially
        req(0, 32'hbfc0_0004);
        step();
        chk("r4_pc",    fetch_pc,        32'hbfc0_0004);
        chk("r4_mask",  32'(fetch_mask), 32'h2);
        chk("r4_src",   32'(redir_src),  32'd1);
        chk("r4_flush", 32'(flush),      32'd1);
        clr_redir(); fetch_ready = 1'b1;
        step();
        chk("seq_pc",    fetch_pc,        32'hbfc0_0008);
        chk("seq_mask",  32'(fetch_mask), 32'h3);
        chk("seq_src",   32'(redir_src),  32'd0);
        chk("seq_flush", 32'(flush),      32'd0);
        fetch_ready = 1'b0;

        // Two channels; channel 1 beats channel 3, fetch_ready low
        req(1, 32'h8000_1000); req(3, 32'h8000_2000);
        step();
        chk("pri_pc",    fetch_pc,       32'h8000_1000);
        chk("pri_src",   32'(redir_src), 32'd2);
        chk("pri_flush", 32'(flush),     32'd1);
        clr_redir();
        step();
        chk("pri_flush2", 32'(flush), 32'd0);
        chk("pri_pc2",    fetch_pc,   32'h8000_1000);

        // Hold: ch3 parks, ch2 replaces it, quiet cycle, ch3 dropped
        hold = 1'b1; fetch_ready = 1'b1; req(3, 32'h100);
        step();
        chk("h0_pc", fetch_pc, 32'h8000_1000);
        clr_redir(); req(2, 32'h200);
        step();
        chk("h1_pc", fetch_pc, 32'h8000_1000);
        chk("h1_flush", 32'(flush), 32'd0);
        clr_redir();
        step();
        chk("h2_pc",  fetch_pc,       32'h8000_1000);
        chk("h2_src", 32'(redir_src), 32'd2);
        req(3, 32'h900);
        step();
        chk("h3_pc", fetch_pc, 32'h8000_1000);
        clr_redir(); hold = 1'b0; fetch_ready = 1'b0;
        step();
        chk("hrel_pc",    fetch_pc,       32'h200);
        chk("hrel_src",   32'(redir_src), 32'd3);
        chk("hrel_flush", 32'(flush),     32'd1);
        step();
        chk("hclr_pc",    fetch_pc,   32'h200);
        chk("hclr_flush", 32'(flush), 32'd0);

        // Redirect beats prediction in the same cycle
        fetch_ready = 1'b1; pred_taken = 1'b1; pred_pc = 32'h400;
        req(0, 32'hbfc0_0380);
        step();
        chk("rvp_pc",  fetch_pc,       32'hbfc0_0380);
        chk("rvp_src", 32'(redir_src), 32'd1);
        clr_redir(); fetch_ready = 1'b0;
        step();
        chk("pnr_pc", fetch_pc, 32'hbfc0_0380);
        fetch_ready = 1'b1;
        step();
        chk("pred_pc",    fetch_pc,       32'h400);
        chk("pred_src",   32'(redir_src), 32'd0);
        chk("pred_flush", 32'(flush),     32'd0);
        pred_taken = 1'b0; fetch_ready = 1'b0;

        // 32-bit wrap of the sequential increment
        req(0, 32'hffff_fff8);
        step();
        clr_redir(); fetch_ready = 1'b1;
        step();
        chk("wrap_pc",   fetch_pc,        32'h0);
        chk("wrap_mask", 32'(fetch_mask), 32'h3);
        fetch_ready = 1'b0;

        // Misaligned targets
        req(1, 32'h8000_0002);
        step();
        chk("mis2_flag",  32'(pc_misalign), 32'd1);
        chk("mis2_mask",  32'(fetch_mask),  32'h1);
        chk("mis2_valid", 32'(fetch_valid), 32'd1);
        clr_redir(); req(1, 32'h8000_0006);
        step();
        chk("mis6_flag", 32'(pc_misalign), 32'd1);
        chk("mis6_mask", 32'(fetch_mask),  32'h2);
        clr_redir();

        // Reset while a redirect is pending
        hold = 1'b1; req(3, 32'h300);
        step();
        resetn = 1'b0;
        #1;
        chk("arst_valid", 32'(fetch_valid), 32'd0);
        chk("arst_pc",    fetch_pc,         32'hbfc0_0000);
        clr_redir(); hold = 1'b0;
        step();
        resetn = 1'b1;
        step();
        chk("rel_valid", 32'(fetch_valid), 32'd1);
        chk("rel_pc",    fetch_pc,         32'hbfc0_0000);
        step();
        chk("rel_pc2",   fetch_pc,   32'hbfc0_0000);
        chk("rel_flush", 32'(flush), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
